// File: rtl/stack_bus_upstream_arb.sv
// Merges NUM_PE upstream packet streams onto one manager channel through per-PE FIFOs
// and a packet-locked round-robin arbiter that tags each packet with its source PE.
module stack_bus_upstream_arb #(
  parameter int NUM_PE     = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = 2
) (
  input  logic                     clk,
  input  logic                     reset_poweron,
  input  logic [NUM_PE-1:0]        pe_up_valid,
  input  logic [NUM_PE*DATA_W-1:0] pe_up_data,
  input  logic [NUM_PE-1:0]        pe_up_eop,
  output logic [NUM_PE-1:0]        pe_up_ready,
  output logic                     mgr_up_valid,
  output logic [DATA_W-1:0]        mgr_up_data,
  output logic                     mgr_up_eop,
  output logic [SRC_W-1:0]         mgr_up_src,
  input  logic                     mgr_up_ready,
  output logic [15:0]              pkt_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, XFER} state_t;

  // Each entry stores {eop, data}.
  logic [DATA_W:0]    mem    [NUM_PE][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_PE];
  logic [PTR_W-1:0]   rd_ptr [NUM_PE];
  logic [CNT_W-1:0]   count  [NUM_PE];

  logic [NUM_PE-1:0]  full, empty, push, pop;
  state_t             state;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_last;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_found;
  logic [DATA_W:0]    head;
  logic               xfer_pop;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    pop   = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      empty[i] = (count[i] == '0);
      push[i]  = pe_up_valid[i] & ~full[i];
      pop[i]   = xfer_pop & (grant == SRC_W'(i));
    end
  end

  // Ready comes from registered occupancy only, so a full FIFO refuses a push even while popping.
  assign pe_up_ready = ~full;

  assign head         = mem[grant][rd_ptr[grant]];
  assign mgr_up_valid = (state == XFER) & ~empty[grant];
  assign mgr_up_data  = mgr_up_valid ? head[DATA_W-1:0] : '0;
  assign mgr_up_eop   = mgr_up_valid & head[DATA_W];
  assign mgr_up_src   = grant;
  assign xfer_pop     = mgr_up_valid & mgr_up_ready;

  // First non-empty FIFO after rr_last, wrapping modulo NUM_PE.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      if (!arb_found && !empty[SRC_W'((int'(rr_last) + k) % NUM_PE)]) begin
        arb_found = 1'b1;
        arb_idx   = SRC_W'((int'(rr_last) + k) % NUM_PE);
      end
    end
  end

  // NOTE: storage arrays are not reset; flushing the pointers and counts empties the FIFOs and keeps the RAM reset-free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {pe_up_eop[i], pe_up_data[i*DATA_W +: DATA_W]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int i = 0; i < NUM_PE; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Grant is held until the EOP word leaves, even if the granted FIFO runs dry mid-packet.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state     <= IDLE;
      grant     <= '0;
      rr_last   <= SRC_W'(NUM_PE - 1);
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (xfer_pop && head[DATA_W]) begin
            rr_last   <= grant;
            pkt_count <= pkt_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_bus_upstream_arb.sv
// Directed bench for stack_bus_upstream_arb: a per-cycle vector table plus hand-timed
// sequences for back-pressure, mid-packet starvation, counter wrap and reset flush.
module tb_stack_bus_upstream_arb;

  logic         clk = 1'b0;
  logic         reset_poweron = 1'b1;
  logic [3:0]   pe_up_valid = '0;
  logic [255:0] pe_up_data = '0;
  logic [3:0]   pe_up_eop = '0;
  logic [3:0]   pe_up_ready;
  logic         mgr_up_valid;
  logic [63:0]  mgr_up_data;
  logic         mgr_up_eop;
  logic [1:0]   mgr_up_src;
  logic         mgr_up_ready = 1'b1;
  logic [15:0]  pkt_count;

  int total = 0;
  int bad   = 0;

  stack_bus_upstream_arb #(
    .NUM_PE(4), .DATA_W(64), .FIFO_DEPTH(4), .SRC_W(2)
  ) dut (
    .clk          (clk),
    .reset_poweron(reset_poweron),
    .pe_up_valid  (pe_up_valid),
    .pe_up_data   (pe_up_data),
    .pe_up_eop    (pe_up_eop),
    .pe_up_ready  (pe_up_ready),
    .mgr_up_valid (mgr_up_valid),
    .mgr_up_data  (mgr_up_data),
    .mgr_up_eop   (mgr_up_eop),
    .mgr_up_src   (mgr_up_src),
    .mgr_up_ready (mgr_up_ready),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  pv;
    logic [7:0]  word;
    logic [3:0]  peop;
    logic        mrdy;
    logic        ev;
    logic [63:0] ed;
    logic        ee;
    logic [1:0]  es;
    logic [3:0]  er;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic ev, input logic [63:0] ed,
                               input logic ee, input logic [1:0] es, input logic [3:0] er,
                               input logic [15:0] ec);
    check({name, ".valid"}, 64'(mgr_up_valid), 64'(ev));
    check({name, ".data"},  mgr_up_data,       ed);
    check({name, ".eop"},   64'(mgr_up_eop),   64'(ee));
    check({name, ".src"},   64'(mgr_up_src),   64'(es));
    check({name, ".ready"}, 64'(pe_up_ready),  64'(er));
    check({name, ".count"}, 64'(pkt_count),    64'(ec));
  endtask

  // Lane i carries {i, word} so the source of every word is visible in the data.
  task automatic drive(input logic [3:0] pv, input logic [7:0] word, input logic [3:0] peop);
    pe_up_valid = pv;
    pe_up_eop   = peop;
    for (int i = 0; i < 4; i++)
      pe_up_data[i*64 +: 64] = pv[i] ? ((64'(i) << 8) | 64'(word)) : 64'h0;
  endtask

  // Ends on a negedge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    drive(4'h0, 8'h00, 4'h0);
    reset_poweron = 1'b0;
    #1;
    check_outputs("rst_during", 1'b0, 64'h0, 1'b0, 2'd0, 4'hF, 16'h0);
    repeat (2) @(negedge clk);
    check_outputs("rst_held", 1'b0, 64'h0, 1'b0, 2'd0, 4'hF, 16'h0);
    reset_poweron = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r;
    bit saw_full, have_held;
    logic [63:0] held_data;
    logic [2:0]  held_tag;

    // Single 3-word packet from PE2, then four simultaneous 2-word packets after a fresh reset.
    vecs.push_back('{1'b1, 4'h4, 8'h0A, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h4, 8'h0B, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h4, 8'h0C, 4'h4, 1'b1, 1'b1, 64'h020A, 1'b0, 2'd2, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h020B, 1'b0, 2'd2, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h020C, 1'b1, 2'd2, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd2, 4'hF, 16'd1});
    vecs.push_back('{1'b1, 4'hF, 8'h31, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'hF, 8'h32, 4'hF, 1'b1, 1'b0, 64'h0,    1'b0, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0031, 1'b0, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0032, 1'b1, 2'd0, 4'hF, 16'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd0, 4'hF, 16'd1});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0131, 1'b0, 2'd1, 4'hF, 16'd1});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0132, 1'b1, 2'd1, 4'hF, 16'd1});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd1, 4'hF, 16'd2});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0231, 1'b0, 2'd2, 4'hF, 16'd2});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0232, 1'b1, 2'd2, 4'hF, 16'd2});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd2, 4'hF, 16'd3});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0331, 1'b0, 2'd3, 4'hF, 16'd3});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 64'h0332, 1'b1, 2'd3, 4'hF, 16'd3});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 64'h0,    1'b0, 2'd3, 4'hF, 16'd4});

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      else @(negedge clk);
      check_outputs($sformatf("vec%0d", n), vecs[n].ev, vecs[n].ed, vecs[n].ee,
                    vecs[n].es, vecs[n].er, vecs[n].ec);
      mgr_up_ready = vecs[n].mrdy;
      drive(vecs[n].pv, vecs[n].word, vecs[n].peop);
    end

    // Manager stalls 10 cycles while PE1 streams a 6-word packet.
    do_reset();
    k = 0; r = 0; saw_full = 0; have_held = 0;
    held_data = '0; held_tag = '0;
    for (int cyc = 0; cyc < 40 && r < 6; cyc++) begin
      mgr_up_ready = (cyc >= 10);
      if (k == 4 && cyc < 10 && !saw_full) begin
        check("t4_ready_drop", 64'(pe_up_ready), 64'h0D);
        saw_full = 1;
      end
      if (mgr_up_valid) begin
        if (!mgr_up_ready) begin
          if (have_held) begin
            check("t4_hold_data", mgr_up_data, held_data);
            check("t4_hold_tag", 64'({mgr_up_eop, mgr_up_src}), 64'(held_tag));
          end
          held_data = mgr_up_data;
          held_tag  = {mgr_up_eop, mgr_up_src};
          have_held = 1;
        end else begin
          check($sformatf("t4_word%0d", r), mgr_up_data, 64'h0140 + 64'(r));
          check($sformatf("t4_eop%0d", r), 64'(mgr_up_eop), 64'(r == 5));
          check($sformatf("t4_src%0d", r), 64'(mgr_up_src), 64'd1);
          r++;
        end
      end
      if (k < 6 && pe_up_ready[1]) begin
        drive(4'b0010, 8'h40 + 8'(k), (k == 5) ? 4'b0010 : 4'b0000);
        k++;
      end else begin
        drive(4'h0, 8'h00, 4'h0);
      end
      @(negedge clk);
    end
    check("t4_words_received", 64'(r), 64'd6);
    check("t4_count", 64'(pkt_count), 64'd1);

    // PE0 stalls mid-packet; PE3 must wait for PE0's EOP.
    do_reset();
    mgr_up_ready = 1'b1;
    drive(4'b1001, 8'h51, 4'b0000);
    @(negedge clk); drive(4'b1000, 8'h52, 4'b1000);
    @(negedge clk); drive(4'h0, 8'h00, 4'h0);
    check_outputs("t5_first", 1'b1, 64'h0051, 1'b0, 2'd0, 4'hF, 16'd0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("t5_gap_valid%0d", j), 64'(mgr_up_valid), 64'd0);
      check($sformatf("t5_gap_src%0d", j), 64'(mgr_up_src), 64'd0);
    end
    drive(4'b0001, 8'h52, 4'b0001);
    @(negedge clk); drive(4'h0, 8'h00, 4'h0);
    check_outputs("t5_pe0_eop", 1'b1, 64'h0052, 1'b1, 2'd0, 4'hF, 16'd0);
    @(negedge clk); check_outputs("t5_bubble", 1'b0, 64'h0, 1'b0, 2'd0, 4'hF, 16'd1);
    @(negedge clk); check_outputs("t5_pe3_w0", 1'b1, 64'h0351, 1'b0, 2'd3, 4'hF, 16'd1);
    @(negedge clk); check_outputs("t5_pe3_w1", 1'b1, 64'h0352, 1'b1, 2'd3, 4'hF, 16'd1);
    @(negedge clk); check_outputs("t5_done", 1'b0, 64'h0, 1'b0, 2'd3, 4'hF, 16'd2);

    // Counter preloaded to 0xFFFF stands in for 65535 one-word packets.
    force dut.pkt_count = 16'hFFFF;
    #1 release dut.pkt_count;
    check("t6_preload", 64'(pkt_count), 64'hFFFF);
    drive(4'b0010, 8'h71, 4'b0010);
    @(negedge clk); drive(4'h0, 8'h00, 4'h0);
    @(negedge clk); check_outputs("t6_last_pkt", 1'b1, 64'h0171, 1'b1, 2'd1, 4'hF, 16'hFFFF);
    @(negedge clk); check("t6_wrap", 64'(pkt_count), 64'h0000);

    // Reset in the middle of a PE2 packet with a PE3 word still queued.
    drive(4'b0100, 8'h81, 4'b0000);
    @(negedge clk); drive(4'h0, 8'h00, 4'h0);
    @(negedge clk); drive(4'b1000, 8'h82, 4'b0000);
    check_outputs("t6_partial", 1'b1, 64'h0281, 1'b0, 2'd2, 4'hF, 16'd0);
    do_reset();
    check_outputs("t6_after_rst", 1'b0, 64'h0, 1'b0, 2'd0, 4'hF, 16'd0);
    drive(4'b1010, 8'h91, 4'b1010);
    @(negedge clk); drive(4'h0, 8'h00, 4'h0);
    @(negedge clk); check_outputs("t6_first_after_rst", 1'b1, 64'h0191, 1'b1, 2'd1, 4'hF, 16'd0);
    @(negedge clk); check_outputs("t6_bubble", 1'b0, 64'h0, 1'b0, 2'd1, 4'hF, 16'd1);
    @(negedge clk); check_outputs("t6_second", 1'b1, 64'h0391, 1'b1, 2'd3, 4'hF, 16'd1);
    @(negedge clk); check_outputs("t6_end", 1'b0, 64'h0, 1'b0, 2'd3, 4'hF, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
